// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the line-granular memory model.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, GNT} mem_state_t;
    typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

    localparam int unsigned WORD_W = 32;

    function automatic int unsigned line_size(input int unsigned line_addr_len);
        return 32'd1 << line_addr_len;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Whole-line word array: synchronous write, combinational read.
// Each line powers up holding its own word addresses.
module line_ram
    import mem_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_LEN      = 9
) (
    input  logic                                         clk,
    input  logic                                         we,
    input  logic [ADDR_LEN-1:0]                          waddr,
    input  logic [WORD_W*line_size(LINE_ADDR_LEN)-1:0]   wdata,
    input  logic [ADDR_LEN-1:0]                          raddr,
    output logic [WORD_W*line_size(LINE_ADDR_LEN)-1:0]   rdata
);

    localparam int unsigned LW    = WORD_W * line_size(LINE_ADDR_LEN);
    localparam int unsigned DEPTH = 32'd1 << ADDR_LEN;

    logic [LW-1:0] lines [DEPTH];

    function automatic logic [LW-1:0] init_line(input int unsigned l);
        logic [LW-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < line_size(LINE_ADDR_LEN); k++) begin
            v[k*WORD_W +: WORD_W] = WORD_W'((l << LINE_ADDR_LEN) + k);
        end
        return v;
    endfunction

    for (genvar l = 0; l < DEPTH; l++) begin : g_line
        logic [LW-1:0] q = init_line(l);

        always_ff @(posedge clk) begin
            if (we && waddr == ADDR_LEN'(l)) begin
                q <= wdata;
            end
        end

        assign lines[l] = q;
    end

    assign rdata = lines[raddr];

endmodule

// File: rtl/line_mem_ctrl.sv
// Line memory controller: fixed-latency whole-line read/write with
// a one-cycle completion pulse and traffic counters.
module line_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_LEN      = 9,
    parameter int unsigned LATENCY       = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [ADDR_LEN-1:0]                          addr,
    input  logic                                         rd_req,
    input  logic                                         wr_req,
    input  logic [WORD_W*line_size(LINE_ADDR_LEN)-1:0]   wr_line,
    output logic [WORD_W*line_size(LINE_ADDR_LEN)-1:0]   rd_line,
    output logic                                         gnt,
    output logic [31:0]                                  rd_cnt,
    output logic [31:0]                                  wr_cnt
);

    localparam int unsigned LW = WORD_W * line_size(LINE_ADDR_LEN);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (LATENCY < 1) begin : g_bad_latency
        $error("line_mem_ctrl: LATENCY must be >= 1");
    end

    mem_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    mem_op_t             op_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [LW-1:0]       line_q;
    logic [LW-1:0]       ram_rdata;
    logic                accept;
    logic                commit;
    logic                ram_we;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    accept  = 1'b1;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = GNT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GNT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are captured once; the requester may drop them after.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= wr_req ? OP_WRITE : OP_READ;
            addr_q <= addr;
            line_q <= wr_line;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt     <= 1'b0;
            rd_line <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
        end else begin
            gnt <= commit;
            if (commit && op_q == OP_READ) begin
                rd_line <= ram_rdata;
                rd_cnt  <= rd_cnt + 32'd1;
            end
            if (commit && op_q == OP_WRITE) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

    assign ram_we = commit && op_q == OP_WRITE;

    line_ram #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .ADDR_LEN      (ADDR_LEN)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (line_q),
        .raddr (addr_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Directed bench for line_mem_ctrl at LATENCY=4 plus a LATENCY=1 build.
module tb_line_mem_ctrl;

    typedef logic [255:0] line_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  addr = '0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    line_t       wr_line = '0;
    line_t       rd_line;
    logic        gnt;
    logic [31:0] rd_cnt, wr_cnt;

    logic [8:0]  addr1 = '0;
    logic        rd_req1 = 1'b0;
    logic        wr_req1 = 1'b0;
    line_t       wr_line1 = '0;
    line_t       rd_line1;
    logic        gnt1;
    logic [31:0] rd_cnt1, wr_cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    line_mem_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req),
        .wr_req(wr_req), .wr_line(wr_line), .rd_line(rd_line),
        .gnt(gnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    line_mem_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .addr(addr1), .rd_req(rd_req1),
        .wr_req(wr_req1), .wr_line(wr_line1), .rd_line(rd_line1),
        .gnt(gnt1), .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
    );

    function automatic line_t init_line(input int l);
        line_t v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = 32'((l << 3) + k);
        return v;
    endfunction

    function automatic line_t seq_line(input logic [31:0] base);
        line_t v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = base + 32'(k);
        return v;
    endfunction

    function automatic line_t fill_line(input logic [31:0] w);
        line_t v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = w;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0;
        rd_req1 = 1'b0; wr_req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Counts edges until gnt is seen at a negedge; -1 if it never comes.
    task automatic wait_gnt(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (gnt) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic w, input logic r, input logic [8:0] a,
                          input line_t d, input bit pulse, output int lat);
        @(posedge clk);
        #1;
        wr_req = w; rd_req = r; addr = a; wr_line = d;
        @(posedge clk);
        if (pulse) begin
            #1;
            wr_req = 1'b0; rd_req = 1'b0;
        end
        wait_gnt(lat);
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        if (gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0", gnt); end
        total++;
        if (rd_line !== '0) begin bad++; $display("FAIL reset_rd_line got=%h want=0", rd_line); end
        total++;
        if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", rd_cnt, wr_cnt);
        end
        total++;
        if (gnt1 !== 1'b0) begin bad++; $display("FAIL reset_gnt1 got=%b want=0", gnt1); end
        total++;
    endtask

    task automatic test_read();
        int lat;
        do_reset();
        run_op(1'b0, 1'b1, 9'h005, '0, 1'b0, lat);
        if (lat !== 4) begin bad++; $display("FAIL read_latency got=%0d want=4", lat); end
        total++;
        @(negedge clk);
        if (gnt !== 1'b0) begin bad++; $display("FAIL read_gnt_width got=%b want=0", gnt); end
        total++;
        if (rd_line !== init_line(5)) begin
            bad++; $display("FAIL read_line got=%h want=%h", rd_line, init_line(5));
        end
        total++;
        if (rd_cnt !== 32'd1 || wr_cnt !== 32'd0) begin
            bad++; $display("FAIL read_cnt got=%0d/%0d want=1/0", rd_cnt, wr_cnt);
        end
        total++;
    endtask

    task automatic test_write_then_read();
        int lat, gap;
        do_reset();
        @(posedge clk);
        #1;
        wr_req = 1'b1; addr = 9'h1FF; wr_line = seq_line(32'hA0);
        @(posedge clk);
        wait_gnt(lat);
        wr_req = 1'b0; rd_req = 1'b1;
        wait_gnt(gap);
        rd_req = 1'b0;
        if (lat !== 4) begin bad++; $display("FAIL wtr_write_latency got=%0d want=4", lat); end
        total++;
        if (gap !== 6) begin bad++; $display("FAIL wtr_gnt_spacing got=%0d want=6", gap); end
        total++;
        if (rd_line !== seq_line(32'hA0)) begin
            bad++; $display("FAIL wtr_line got=%h want=%h", rd_line, seq_line(32'hA0));
        end
        total++;
        if (rd_cnt !== 32'd1 || wr_cnt !== 32'd1) begin
            bad++; $display("FAIL wtr_cnt got=%0d/%0d want=1/1", rd_cnt, wr_cnt);
        end
        total++;
    endtask

    task automatic test_dropped_request();
        int lat;
        do_reset();
        run_op(1'b0, 1'b1, 9'h0A0, '0, 1'b1, lat);
        if (lat !== 4) begin bad++; $display("FAIL drop_latency got=%0d want=4", lat); end
        total++;
        if (rd_line !== init_line(9'h0A0)) begin
            bad++; $display("FAIL drop_line got=%h want=%h", rd_line, init_line(9'h0A0));
        end
        total++;
        if (rd_cnt !== 32'd1) begin bad++; $display("FAIL drop_cnt got=%0d want=1", rd_cnt); end
        total++;
    endtask

    task automatic test_simultaneous();
        int lat;
        do_reset();
        run_op(1'b1, 1'b1, 9'h003, fill_line(32'h55), 1'b0, lat);
        if (lat !== 4) begin bad++; $display("FAIL both_latency got=%0d want=4", lat); end
        total++;
        if (wr_cnt !== 32'd1 || rd_cnt !== 32'd0) begin
            bad++; $display("FAIL both_cnt got=%0d/%0d want=0/1", rd_cnt, wr_cnt);
        end
        total++;
        if (rd_line !== '0) begin bad++; $display("FAIL both_rd_line got=%h want=0", rd_line); end
        total++;
        run_op(1'b0, 1'b1, 9'h003, '0, 1'b0, lat);
        if (rd_line !== fill_line(32'h55)) begin
            bad++; $display("FAIL both_readback got=%h want=%h", rd_line, fill_line(32'h55));
        end
        total++;
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        do_reset();
        @(posedge clk);
        #1;
        wr_req = 1'b1; addr = 9'h007; wr_line = fill_line(32'hDEADBEEF);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; wr_req = 1'b0;
        #1;
        if (gnt !== 1'b0) begin bad++; $display("FAIL abort_gnt got=%b want=0", gnt); end
        total++;
        repeat (4) @(negedge clk);
        if (gnt !== 1'b0) begin bad++; $display("FAIL abort_gnt_held got=%b want=0", gnt); end
        total++;
        @(posedge clk);
        #1 rst = 1'b1;
        if (wr_cnt !== 32'd0 || rd_cnt !== 32'd0) begin
            bad++; $display("FAIL abort_cnt got=%0d/%0d want=0/0", rd_cnt, wr_cnt);
        end
        total++;
        run_op(1'b0, 1'b1, 9'h007, '0, 1'b0, lat);
        if (lat !== 4) begin bad++; $display("FAIL abort_read_latency got=%0d want=4", lat); end
        total++;
        if (rd_line !== init_line(7)) begin
            bad++; $display("FAIL abort_line got=%h want=%h", rd_line, init_line(7));
        end
        total++;
        if (wr_cnt !== 32'd0) begin bad++; $display("FAIL abort_wr_cnt got=%0d want=0", wr_cnt); end
        total++;
    endtask

    task automatic test_latency1();
        logic exp_g;
        do_reset();
        @(posedge clk);
        #1;
        rd_req1 = 1'b1; addr1 = 9'h002;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_g = (i % 3 == 1);
            if (gnt1 !== exp_g) begin
                bad++; $display("FAIL lat1_gnt cycle=%0d got=%b want=%b", i, gnt1, exp_g);
            end
            total++;
            if (rd_cnt1 !== 32'((i + 2) / 3)) begin
                bad++; $display("FAIL lat1_cnt cycle=%0d got=%0d want=%0d", i, rd_cnt1, (i + 2) / 3);
            end
            total++;
        end
        rd_req1 = 1'b0;
        repeat (3) @(negedge clk);
        if (rd_cnt1 !== 32'd5) begin bad++; $display("FAIL lat1_final_cnt got=%0d want=5", rd_cnt1); end
        total++;
        if (rd_line1 !== init_line(2)) begin
            bad++; $display("FAIL lat1_line got=%h want=%h", rd_line1, init_line(2));
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_then_read();
        test_dropped_request();
        test_simultaneous();
        test_reset_mid_busy();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_mem_ctrl.md
Name: line_mem_ctrl

Overview:
Line-granular main-memory model with programmable access latency. It is the backing store directly downstream of the set-associative cache.
- Accepts one whole-line read or write per request and completes it after LATENCY cycles.
- Acknowledges completion with a one-cycle gnt pulse.
- Counts completed reads and writes so cache experiments can report memory traffic.

Parameters:
- LINE_ADDR_LEN, 3: log2 of words per line (LINE_SIZE = 2^LINE_ADDR_LEN).
- ADDR_LEN, 9: line address width; the memory holds 2^ADDR_LEN lines.
- LATENCY, 4: cycles from request acceptance to gnt. Must be >= 1; elaboration error otherwise.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- addr, input, ADDR_LEN: line address, sampled at acceptance.
- rd_req, input, 1: line read request, level.
- wr_req, input, 1: line write request, level.
- wr_line, input, 32 x LINE_SIZE: line to write, sampled at acceptance.
- rd_line, output, 32 x LINE_SIZE: last line read, registered.
- gnt, output, 1: completion pulse, registered.
- rd_cnt, output, 32: completed reads.
- wr_cnt, output, 32: completed writes.

Behaviour:
- Reset values: gnt=0, rd_line all 0, rd_cnt=0, wr_cnt=0, state IDLE, delay counter 0.
- Reset does not touch array contents.
- Array initial content (simulation init): word k of line L = (L << LINE_ADDR_LEN) + k.
- State IDLE:
  - If wr_req|rd_req, latch addr, op and wr_line; load counter with LATENCY-1; go to BUSY.
  - wr_req has priority when both requests are high; op=WRITE.
- State BUSY:
  - Counter decrements each cycle.
  - When counter==0 the operation commits:
    - WRITE: array[addr_latched] <= wr_line_latched; wr_cnt++.
    - READ: rd_line <= array[addr_latched]; rd_cnt++.
  - In the same edge, gnt <= 1 and the block goes to GNT.
- State GNT:
  - gnt is high for exactly this one cycle. Requests seen during this cycle are ignored.
  - Next edge: gnt <= 0, go to IDLE.
  - A request still high in the following IDLE cycle is accepted as a new operation.
- Timing:
  - Acceptance edge to gnt high: exactly LATENCY cycles.
  - Minimum spacing between back-to-back operations: LATENCY+2 cycles.
- rd_line:
  - Changes only at a READ commit.
  - Stable through the gnt cycle and every cycle after, until the next read commits.
  - The requester may capture it in the cycle after gnt.
- Request dropped while BUSY: the operation still completes and gnt still pulses (the operation is committed at acceptance).
- Write then read with the write-then-read sequence:
  - Requester holds wr_req through gnt, then switches to rd_req.
  - The read is accepted the cycle after GNT.
  - A read of the just-written address returns the new data.
- Counters: 32-bit, wrap from 0xFFFF_FFFF to 0, no saturation.
- Reset asserted mid-BUSY: the operation is aborted, no array write, counters not incremented, gnt=0 immediately.
- addr is used in full; there is no out-of-range case.

Decomposition:
- Package mem_pkg holds:
  - typedef enum {IDLE, BUSY, GNT} mem_state_t;
  - typedef enum {OP_READ, OP_WRITE} mem_op_t;
  - localparam helper LINE_SIZE(LINE_ADDR_LEN).
- One natural sub-module, line_ram: the 2^ADDR_LEN x LINE_SIZE word array.
  - Synchronous whole-line write on we.
  - Combinational whole-line read.
  - Carries the init pattern.
- line_mem_ctrl holds the FSM, delay counter, latches and statistics counters.

Test Plan:
- Read, LATENCY=4: rd_req=1, addr=0x005 at edge 0.
  -> gnt high in the cycle after edge 4, one cycle only.
  -> rd_line = {0x28..0x2F}; rd_cnt=1.
- Write then read: wr_req, addr=0x1FF, wr_line={0xA0..0xA7}; after gnt, switch to rd_req, same addr.
  -> read accepted the cycle after gnt.
  -> rd_line={0xA0..0xA7}; wr_cnt=1, rd_cnt=1; total time 2*(LATENCY+1)+1 cycles.
- Request dropped while BUSY: rd_req pulsed for one cycle only.
  -> gnt still pulses LATENCY cycles later.
  -> rd_line updated; rd_cnt=1.
- Simultaneous rd_req and wr_req, addr=3, wr_line all 0x55.
  -> treated as a write, wr_cnt=1, rd_cnt=0, rd_line unchanged.
  -> a subsequent read of line 3 returns all 0x55.
- Reset mid-BUSY: write to addr 7, then rst low on the second BUSY cycle.
  -> gnt=0, counters 0.
  -> after release, a read of line 7 returns init pattern {0x38..0x3F}.
- LATENCY=1 build with continuously held rd_req.
  -> gnt every 3rd cycle.
  -> rd_cnt increments once per gnt; no double-accept during GNT.
